// File: rtl/add_pkg.sv
// Shared types and helpers for the add/accumulate control stage.
// Holds the FSM state encoding and the signed-overflow rule applied to the adder result.
package add_pkg;

   localparam int WIDTH_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      HOLD    = 2'd2
   } state_t;

   // Two's-complement overflow: like-signed operands producing a sum of the other sign.
   function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic sum_msb);
      return (a_msb == b_msb) && (sum_msb != a_msb);
   endfunction

endpackage

// File: rtl/add_accumulate_ctrl_reg_n.sv
// WIDTH-bit register with synchronous active-low reset, synchronous clear and load.
// Priority is reset, then clear, then load.
module reg_n #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Storage with reset > clear > load priority
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         q <= {WIDTH{1'b0}};
      end else if (clear) begin
         q <= {WIDTH{1'b0}};
      end else if (load) begin
         q <= d;
      end else begin
         q <= q;
      end
   end

endmodule

// File: rtl/add_accumulate_ctrl.sv
// Operand/result stage around an external carry-lookahead adder: holds A and B,
// and writes sum, carry-out and signed overflow back into A under a run/hold FSM.
module add_accumulate_ctrl
   import add_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Run,
   input  logic             ClearA_LoadB,
   input  logic [WIDTH-1:0] SW,
   output logic [WIDTH-1:0] Adder_A,
   output logic [WIDTH-1:0] Adder_B,
   input  logic [WIDTH-1:0] Adder_Sum,
   input  logic             Adder_Cout,
   output logic [WIDTH-1:0] Acc,
   output logic             Cout,
   output logic             Ovf,
   output logic             Done
);

   state_t           state_r;
   logic             done_r;
   logic             cout_r;
   logic             ovf_r;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;

   logic             in_idle_s;
   logic             clear_load_s;
   logic             a_load_s;

   assign in_idle_s    = (state_r == IDLE);
   // ClearA_LoadB acts only in IDLE, where it also outranks Run
   assign clear_load_s = in_idle_s && ClearA_LoadB;
   assign a_load_s     = (state_r == COMPUTE);

   reg_n #(.WIDTH(WIDTH)) u_reg_a (
      .clk     (Clk),
      .reset_n (Reset),
      .clear   (clear_load_s),
      .load    (a_load_s),
      .d       (Adder_Sum),
      .q       (a_q)
   );

   reg_n #(.WIDTH(WIDTH)) u_reg_b (
      .clk     (Clk),
      .reset_n (Reset),
      .clear   (1'b0),
      .load    (clear_load_s),
      .d       (SW),
      .q       (b_q)
   );

   // Run/hold sequencing plus the latched carry, overflow and Done pulse
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_r <= IDLE;
         done_r  <= 1'b0;
         cout_r  <= 1'b0;
         ovf_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (ClearA_LoadB) begin
                  cout_r <= 1'b0;
                  ovf_r  <= 1'b0;
                  done_r <= 1'b0;
               end else if (Run) begin
                  state_r <= COMPUTE;
                  done_r  <= 1'b1;
               end else begin
                  done_r <= 1'b0;
               end
            end
            COMPUTE: begin
               cout_r  <= Adder_Cout;
               ovf_r   <= signed_ovf(a_q[WIDTH-1], b_q[WIDTH-1], Adder_Sum[WIDTH-1]);
               done_r  <= 1'b0;
               state_r <= HOLD;
            end
            HOLD: begin
               done_r <= 1'b0;
               // Leaving HOLD needs Run released, so a held key yields one add
               if (!Run) begin
                  state_r <= IDLE;
               end else begin
                  state_r <= HOLD;
               end
            end
            default: begin
               state_r <= IDLE;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign Adder_A = a_q;
   assign Adder_B = b_q;
   assign Acc     = a_q;
   assign Cout    = cout_r;
   assign Ovf     = ovf_r;
   assign Done    = done_r;

endmodule

// File: tb/tb_add_accumulate_ctrl.sv
// Scoreboard bench for add_accumulate_ctrl: stimulus pushes expected add results,
// a negedge monitor pops one per Done pulse and compares the written-back state.
module tb_add_accumulate_ctrl;

   logic        Clk;
   logic        Reset;
   logic        Run;
   logic        ClearA_LoadB;
   logic [15:0] SW;
   logic [15:0] Adder_A;
   logic [15:0] Adder_B;
   logic [15:0] Adder_Sum;
   logic        Adder_Cout;
   logic [15:0] Acc;
   logic        Cout;
   logic        Ovf;
   logic        Done;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        c;
      logic        o;
   } exp_t;

   exp_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] m_a = 16'h0000;
   logic [15:0] m_b = 16'h0000;
   logic        m_c = 1'b0;
   logic        m_o = 1'b0;

   add_accumulate_ctrl #(.WIDTH(16)) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .Run          (Run),
      .ClearA_LoadB (ClearA_LoadB),
      .SW           (SW),
      .Adder_A      (Adder_A),
      .Adder_B      (Adder_B),
      .Adder_Sum    (Adder_Sum),
      .Adder_Cout   (Adder_Cout),
      .Acc          (Acc),
      .Cout         (Cout),
      .Ovf          (Ovf),
      .Done         (Done)
   );

   // Stand-in for the external adder, carry-in tied low
   assign {Adder_Cout, Adder_Sum} = {1'b0, Adder_A} + {1'b0, Adder_B};

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Expected result of adding the model's A and B, from integer arithmetic
   function automatic exp_t model_add(input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      int sa;
      int sb;
      int ss;
      int unsigned us;
      sa  = $signed(a);
      sb  = $signed(b);
      ss  = sa + sb;
      us  = int'(a) + int'(b);
      e.a = 16'(us % 65536);
      e.b = b;
      e.c = (us > 65535) ? 1'b1 : 1'b0;
      e.o = (ss > 32767 || ss < -32768) ? 1'b1 : 1'b0;
      return e;
   endfunction

   // Monitor: a Done seen at one negedge means results are visible at the next
   logic done_seen = 1'b0;
   always @(negedge Clk) begin
      exp_t e;
      if (done_seen) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got Done pulse required none (Acc=%0h)", Acc);
         end else begin
            e = exp_q.pop_front();
            check("sb_acc", {16'h0000, Acc}, {16'h0000, e.a});
            check("sb_adder_a", {16'h0000, Adder_A}, {16'h0000, e.a});
            check("sb_b", {16'h0000, Adder_B}, {16'h0000, e.b});
            check("sb_cout", {31'd0, Cout}, {31'd0, e.c});
            check("sb_ovf", {31'd0, Ovf}, {31'd0, e.o});
         end
      end
      done_seen = (Done === 1'b1);
   end

   task automatic do_clear(input logic [15:0] sw, input logic with_run);
      @(negedge Clk);
      SW           = sw;
      ClearA_LoadB = 1'b1;
      Run          = with_run;
      @(negedge Clk);
      ClearA_LoadB = 1'b0;
      Run          = 1'b0;
      SW           = 16'($urandom);
      m_a = 16'h0000;
      m_b = sw;
      m_c = 1'b0;
      m_o = 1'b0;
      check("clr_acc", {16'h0000, Acc}, 32'h0000_0000);
      check("clr_b", {16'h0000, Adder_B}, {16'h0000, sw});
      check("clr_flags", {30'd0, Cout, Ovf}, 32'd0);
   endtask

   // One press of Run held for 'hold' cycles; optionally toggles ClearA_LoadB meanwhile
   task automatic press(input int hold, input logic clr_during);
      exp_t e;
      @(negedge Clk);
      Run = 1'b1;
      e   = model_add(m_a, m_b);
      exp_q.push_back(e);
      m_a = e.a;
      m_c = e.c;
      m_o = e.o;
      repeat (hold) begin
         @(negedge Clk);
         SW           = 16'($urandom);
         ClearA_LoadB = clr_during;
      end
      Run          = 1'b0;
      ClearA_LoadB = 1'b0;
      repeat (2) @(negedge Clk);
      check("press_acc", {16'h0000, Acc}, {16'h0000, m_a});
      check("press_b", {16'h0000, Adder_B}, {16'h0000, m_b});
   endtask

   initial begin
      Reset        = 1'b0;
      Run          = 1'b1;
      ClearA_LoadB = 1'b0;
      SW           = 16'h1234;

      // Reset with Run high, then release with Run dropped
      repeat (2) @(negedge Clk);
      check("rst_acc", {16'h0000, Acc}, 32'd0);
      check("rst_b", {16'h0000, Adder_B}, 32'd0);
      check("rst_flags", {29'd0, Cout, Ovf, Done}, 32'd0);
      Run   = 1'b0;
      Reset = 1'b1;
      repeat (4) @(negedge Clk);
      check("idle_no_add", {16'h0000, Acc}, 32'd0);

      do_clear(16'h0005, 1'b0);
      press(1, 1'b0);
      check("five_once", {16'h0000, Acc}, 32'h0000_0005);
      press(2, 1'b0);
      check("five_twice", {15'd0, Cout, Acc}, 32'h0000_000A);

      do_clear(16'hFFFF, 1'b0);
      press(1, 1'b0);
      check("ffff_once", {14'd0, Cout, Ovf, Acc}, 32'h0000_FFFF);
      press(1, 1'b0);
      check("ffff_twice", {14'd0, Cout, Ovf, Acc}, 32'h0002_FFFE);

      do_clear(16'h8000, 1'b0);
      press(1, 1'b0);
      press(1, 1'b0);
      check("8000_twice", {14'd0, Cout, Ovf, Acc}, 32'h0003_0000);

      do_clear(16'h7FFF, 1'b0);
      press(1, 1'b0);
      press(1, 1'b0);
      check("7fff_twice", {14'd0, Cout, Ovf, Acc}, 32'h0001_FFFE);

      // Reset arriving during COMPUTE discards the add
      @(negedge Clk);
      Run = 1'b1;
      exp_q.push_back('{a: 16'h0000, b: 16'h0000, c: 1'b0, o: 1'b0});
      @(negedge Clk);
      check("compute_done", {31'd0, Done}, 32'd1);
      Reset = 1'b0;
      Run   = 1'b0;
      @(negedge Clk);
      check("midrst_state", {13'd0, Cout, Ovf, Done, Acc}, 32'd0);
      Reset = 1'b1;
      m_a = 16'h0000;
      m_b = 16'h0000;
      m_c = 1'b0;
      m_o = 1'b0;

      do_clear(16'h0123, 1'b0);
      press(50, 1'b0);
      press(6, 1'b1);
      check("hold_clear_ign", {16'h0000, Adder_B}, 32'h0000_0123);
      do_clear(16'h4321, 1'b1);
      repeat (3) @(negedge Clk);
      check("run_clr_noadd", {16'h0000, Acc}, 32'd0);

      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(4))
            0:       do_clear(16'($urandom), 1'($urandom_range(1)));
            default: press($urandom_range(1, 4), 1'($urandom_range(1)));
         endcase
      end

      repeat (3) @(negedge Clk);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
